// File: rtl/banked_poly_memory.sv
// banked_poly_memory: NB-bank / NB-channel coefficient store with rotated bank mapping and DDR burst engine.
// Define MEM_OUTREG_EN to register every RAM read output (read latency 2 instead of 1).
module banked_poly_memory #(
    parameter  int W  = 60,
    parameter  int NB = 2,
    parameter  int RW = 10,
    localparam int LB = $clog2(NB),
    localparam int AW = LB + RW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NB-1:0]    wr_en,
    input  logic [NB*AW-1:0] wr_addr,
    input  logic [NB*W-1:0]  wr_data,
    input  logic             rd_en,
    input  logic [NB*AW-1:0] rd_addr,
    output logic [NB*W-1:0]  rd_data,
    output logic             rd_valid,
    input  logic             xfer_start,
    input  logic             xfer_dir,
    input  logic [RW-1:0]    xfer_row,
    input  logic [RW:0]      xfer_len,
    output logic             busy,
    output logic             done,
    output logic             wr_conflict,
    input  logic             ddr_in_valid,
    output logic             ddr_in_ready,
    input  logic [NB*W-1:0]  ddr_in_data,
    output logic             ddr_out_valid,
    input  logic             ddr_out_ready,
    output logic [NB*W-1:0]  ddr_out_data
);

    localparam int DEPTH = 1 << RW;
    localparam int FD    = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] ptr, ptr_nxt;
    logic [RW:0]   rem, rem_nxt;
    logic          zero_done;
    logic          conflict_q;

    logic          load_beat;
    logic          store_mode;
    logic          issue;
    logic [1:0]    inflight;

    logic [LB-1:0] wr_bsel;
    logic [LB-1:0] rd_bsel;
    logic [NB*W-1:0] ram_q;

    logic          vld_p1;
    logic          iss_p1;
    logic [LB-1:0] rot_p1;
    logic          vld_out;
    logic          iss_out;
    logic [LB-1:0] rot_out;

    logic [NB*W-1:0] fifo_mem [FD];
    logic [1:0]      fifo_wp, fifo_rp;
    logic [2:0]      fifo_cnt;
    logic            push, pop;

    logic [2*NB*LB-1:0] bank_fields_unused;

    // Only channel 0 carries the bank selector; the rotation makes the other fields redundant.
    assign wr_bsel = wr_addr[AW-1:RW];
    assign rd_bsel = rd_addr[AW-1:RW];

    for (genvar c = 0; c < NB; c++) begin : g_bank_field
        assign bank_fields_unused[2*c*LB +: 2*LB] = {wr_addr[c*AW+RW +: LB], rd_addr[c*AW+RW +: LB]};
    end

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE) || zero_done;
    assign wr_conflict  = conflict_q;
    assign ddr_in_ready = (state == S_LOAD);
    assign store_mode   = (state == S_STORE);
    assign load_beat    = (state == S_LOAD) && ddr_in_valid;

    // Credit check counts reads still travelling through the RAM pipeline.
    assign issue = store_mode && (rem != '0) && ((4'(fifo_cnt) + 4'(inflight)) < 4'(FD));

    // Stage p0 -> p1: bank RAMs with compute/LOAD write mux and compute/STORE read mux
    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [LB-1:0]  wch;
        logic [LB-1:0]  rch;
        logic           we;
        logic [RW-1:0]  wrow;
        logic [RW-1:0]  rrow;
        logic [W-1:0]   wdat;
        logic [W-1:0]   mem [DEPTH];
        logic [W-1:0]   q_p1;

        assign wch = LB'(b) - wr_bsel;
        assign rch = LB'(b) - rd_bsel;

        always_comb begin
            we   = wr_en[wch] && !busy;
            wrow = wr_addr[wch*AW +: RW];
            wdat = wr_data[wch*W +: W];
            if (load_beat) begin
                we   = 1'b1;
                wrow = ptr;
                wdat = ddr_in_data[b*W +: W];
            end
            rrow = store_mode ? ptr : rd_addr[rch*AW +: RW];
        end

        always_ff @(posedge clk) begin
            if (we) begin
                mem[wrow] <= wdat;
            end
            q_p1 <= mem[rrow];
        end

`ifdef MEM_OUTREG_EN
        // Stage p1 -> p2: RAM output register
        logic [W-1:0] q_p2;
        always_ff @(posedge clk) begin
            q_p2 <= q_p1;
        end
        assign ram_q[b*W +: W] = q_p2;
`else
        assign ram_q[b*W +: W] = q_p1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            iss_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_en && !busy;
            iss_p1 <= issue;
        end
    end

    always_ff @(posedge clk) begin
        rot_p1 <= rd_bsel;
    end

`ifdef MEM_OUTREG_EN
    logic          vld_p2;
    logic          iss_p2;
    logic [LB-1:0] rot_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            iss_p2 <= 1'b0;
        end else begin
            vld_p2 <= vld_p1;
            iss_p2 <= iss_p1;
        end
    end

    always_ff @(posedge clk) begin
        rot_p2 <= rot_p1;
    end

    assign vld_out  = vld_p2;
    assign iss_out  = iss_p2;
    assign rot_out  = rot_p2;
    assign inflight = {1'b0, iss_p1} + {1'b0, iss_p2};
`else
    assign vld_out  = vld_p1;
    assign iss_out  = iss_p1;
    assign rot_out  = rot_p1;
    assign inflight = {1'b0, iss_p1};
`endif

    // Output stage: undo the rotation so channel c sees the bank it addressed
    for (genvar c = 0; c < NB; c++) begin : g_ch
        logic [LB-1:0] bk;
        assign bk = LB'(c) + rot_out;
        assign rd_data[c*W +: W] = vld_out ? ram_q[bk*W +: W] : '0;
    end
    assign rd_valid = vld_out;

    // STORE skid FIFO
    assign push          = iss_out;
    assign pop           = ddr_out_valid && ddr_out_ready;
    assign ddr_out_valid = (fifo_cnt != 3'd0);
    assign ddr_out_data  = ddr_out_valid ? fifo_mem[fifo_rp] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wp  <= 2'd0;
            fifo_rp  <= 2'd0;
            fifo_cnt <= 3'd0;
        end else begin
            if (push) begin
                fifo_wp <= fifo_wp + 2'd1;
            end
            if (pop) begin
                fifo_rp <= fifo_rp + 2'd1;
            end
            fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wp] <= ram_q;
        end
    end

    // Transfer FSM
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        rem_nxt   = rem;
        case (state)
            S_IDLE: begin
                if (xfer_start && (xfer_len != '0)) begin
                    state_nxt = xfer_dir ? S_STORE : S_LOAD;
                    ptr_nxt   = xfer_row;
                    rem_nxt   = xfer_len;
                end
            end
            S_LOAD: begin
                if (load_beat) begin
                    ptr_nxt = ptr + 1'b1;
                    rem_nxt = rem - 1'b1;
                    if (rem == (RW+1)'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_STORE: begin
                if (issue) begin
                    ptr_nxt = ptr + 1'b1;
                    rem_nxt = rem - 1'b1;
                end
                if ((rem == '0) && (inflight == 2'd0) && (fifo_cnt == 3'd0)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            rem        <= '0;
            zero_done  <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            rem       <= rem_nxt;
            zero_done <= (state == S_IDLE) && xfer_start && (xfer_len == '0);
            if ((state == S_IDLE) && xfer_start) begin
                conflict_q <= 1'b0;
            end else if (busy && (wr_en != '0)) begin
                conflict_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_banked_poly_memory.sv
// tb_banked_poly_memory: randomized self-checking bench against an array model of the banked store.
// Honours MEM_OUTREG_EN for the expected read latency.
module tb_banked_poly_memory;

    localparam int W  = 60;
    localparam int NB = 2;
    localparam int RW = 10;
    localparam int AW = 11;
`ifdef MEM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NB-1:0]   wr_en = '0;
    logic [NB*AW-1:0] wr_addr = '0;
    logic [NB*W-1:0] wr_data = '0;
    logic            rd_en = 1'b0;
    logic [NB*AW-1:0] rd_addr = '0;
    logic [NB*W-1:0] rd_data;
    logic            rd_valid;
    logic            xfer_start = 1'b0;
    logic            xfer_dir = 1'b0;
    logic [RW-1:0]   xfer_row = '0;
    logic [RW:0]     xfer_len = '0;
    logic            busy, done, wr_conflict;
    logic            ddr_in_valid = 1'b0;
    logic            ddr_in_ready;
    logic [NB*W-1:0] ddr_in_data = '0;
    logic            ddr_out_valid;
    logic            ddr_out_ready = 1'b0;
    logic [NB*W-1:0] ddr_out_data;

    banked_poly_memory #(.W(W), .NB(NB), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_row(xfer_row), .xfer_len(xfer_len),
        .busy(busy), .done(done), .wr_conflict(wr_conflict),
        .ddr_in_valid(ddr_in_valid), .ddr_in_ready(ddr_in_ready), .ddr_in_data(ddr_in_data),
        .ddr_out_valid(ddr_out_valid), .ddr_out_ready(ddr_out_ready), .ddr_out_data(ddr_out_data)
    );

    always #5 clk = ~clk;

    // Reference: physical bank contents
    logic [W-1:0] mm [NB][1024];
    int n_total = 0;
    int n_bad = 0;
    int cyc_n = 0;
    logic hv [4];
    logic [NB*W-1:0] hd [4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [W-1:0] rand60();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    function automatic logic [NB*W-1:0] model_row(input int row);
        int r;
        r = row % 1024;
        return {mm[1][r], mm[0][r]};
    endfunction

    task automatic compute_begin();
        cyc_n = 0;
    endtask

    // One compute-port cycle: check the read due now, predict this read, apply writes, drive, advance.
    task automatic compute_cycle(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                                 input logic [W-1:0] wd0, input logic [W-1:0] wd1,
                                 input logic re, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        int idx;
        int b;
        logic [NB*W-1:0] e;
        if (cyc_n >= L) begin
            idx = (cyc_n - L) % 4;
            chk("rd_valid", 128'(rd_valid), 128'(hv[idx]));
            if (hv[idx]) chk("rd_data", 128'(rd_data), 128'(hd[idx]));
        end
        b = int'(ra0[AW-1]);
        e[W-1:0]   = mm[b][ra0[RW-1:0]];
        e[2*W-1:W] = mm[(b + 1) % NB][ra1[RW-1:0]];
        hv[cyc_n % 4] = re;
        hd[cyc_n % 4] = e;
        b = int'(wa0[AW-1]);
        if (we[0]) mm[b][wa0[RW-1:0]] = wd0;
        if (we[1]) mm[(b + 1) % NB][wa1[RW-1:0]] = wd1;
        wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
        rd_en = re; rd_addr = {ra1, ra0};
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic compute_drain();
        for (int i = 0; i < L; i++) compute_cycle(2'b00, '0, '0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic read_row(input int row);
        compute_cycle(2'b00, '0, '0, '0, '0, 1'b1, AW'(row % 1024), AW'(row % 1024));
    endtask

    task automatic do_load(input int row, input int len, input bit conflict);
        int nb;
        int guard;
        logic v;
        int crow;
        xfer_start = 1'b1; xfer_dir = 1'b0; xfer_row = RW'(row); xfer_len = (RW+1)'(len);
        @(negedge clk);
        xfer_start = 1'b0;
        chk("ld_busy", 128'(busy), 128'(1));
        chk("clr_conflict", 128'(wr_conflict), 128'(0));
        if (conflict) begin
            crow = (row + 512) % 1024;
            wr_en = 2'b11; wr_addr = {AW'(crow), AW'(crow)}; wr_data = {rand60(), rand60()};
            rd_en = 1'b1; rd_addr = {AW'(crow), AW'(crow)};
            xfer_start = 1'b1; xfer_dir = 1'b1; xfer_len = 11'd5;
            @(negedge clk);
            wr_en = 2'b00; rd_en = 1'b0; xfer_start = 1'b0;
            chk("conflict_set", 128'(wr_conflict), 128'(1));
            chk("start_ignored", 128'(ddr_in_ready), 128'(1));
            chk("no_store", 128'(ddr_out_valid), 128'(0));
        end
        nb = 0;
        guard = 0;
        while (nb < len && guard < 2000) begin
            chk("busy_rd", 128'(rd_valid), 128'(0));
            chk("ld_done_early", 128'(done), 128'(0));
            v = 1'($urandom_range(0, 1));
            ddr_in_valid = v;
            ddr_in_data = {rand60(), rand60()};
            if (v && ddr_in_ready) begin
                mm[0][(row + nb) % 1024] = ddr_in_data[W-1:0];
                mm[1][(row + nb) % 1024] = ddr_in_data[2*W-1:W];
                nb++;
            end
            @(negedge clk);
            guard++;
        end
        ddr_in_valid = 1'b0;
        chk("ld_beats", 128'(nb), 128'(len));
        chk("ld_done", 128'(done), 128'(1));
        chk("ld_busy_done", 128'(busy), 128'(1));
        @(negedge clk);
        chk("ld_done_pulse", 128'(done), 128'(0));
        chk("ld_idle", 128'(busy), 128'(0));
    endtask

    // mode 0: ready toggles 1,0,1..; 1: random; 2: always ready. abort_at >= 0 stops after that many beats.
    task automatic do_store(input int row, input int len, input int mode, input int abort_at);
        int got;
        int guard;
        logic tog;
        logic rdy;
        logic stalled;
        logic [NB*W-1:0] held;
        xfer_start = 1'b1; xfer_dir = 1'b1; xfer_row = RW'(row); xfer_len = (RW+1)'(len);
        @(negedge clk);
        xfer_start = 1'b0;
        chk("st_busy", 128'(busy), 128'(1));
        got = 0; guard = 0; tog = 1'b1; stalled = 1'b0; held = '0;
        while (!done && guard < 2000) begin
            if (abort_at >= 0 && got == abort_at) break;
            if (stalled) chk("st_hold", 128'(ddr_out_data), 128'(held));
            rdy = (mode == 0) ? tog : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            ddr_out_ready = rdy;
            if (ddr_out_valid) begin
                if (rdy) begin
                    chk("st_beat", 128'(ddr_out_data), 128'(model_row(row + got)));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = ddr_out_data;
                end
            end
            @(negedge clk);
            guard++;
            tog = !tog;
        end
        ddr_out_ready = 1'b0;
        if (abort_at < 0) begin
            chk("st_count", 128'(got), 128'(len));
            chk("st_done", 128'(done), 128'(1));
            @(negedge clk);
            chk("st_done_pulse", 128'(done), 128'(0));
            chk("st_idle", 128'(busy), 128'(0));
            chk("st_drained", 128'(ddr_out_valid), 128'(0));
        end else begin
            chk("st_partial", 128'(got), 128'(abort_at));
        end
    endtask

    task automatic zero_len();
        xfer_start = 1'b1; xfer_dir = 1'($urandom_range(0, 1)); xfer_row = RW'($urandom); xfer_len = '0;
        @(negedge clk);
        xfer_start = 1'b0;
        chk("z_done", 128'(done), 128'(1));
        chk("z_busy", 128'(busy), 128'(0));
        chk("z_in_rdy", 128'(ddr_in_ready), 128'(0));
        chk("z_out_vld", 128'(ddr_out_valid), 128'(0));
        @(negedge clk);
        chk("z_done_pulse", 128'(done), 128'(0));
        chk("z_busy2", 128'(busy), 128'(0));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_conf"}, 128'(wr_conflict), 128'(0));
        chk({tag, "_rdv"}, 128'(rd_valid), 128'(0));
        chk({tag, "_rdd"}, 128'(rd_data), 128'(0));
        chk({tag, "_irdy"}, 128'(ddr_in_ready), 128'(0));
        chk({tag, "_ovld"}, 128'(ddr_out_valid), 128'(0));
        chk({tag, "_odat"}, 128'(ddr_out_data), 128'(0));
    endtask

    initial begin
        logic [W-1:0] a, b2;
        int r;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fill every row of both banks so all later reads are defined
        compute_begin();
        for (int i = 0; i < 1024; i++) compute_cycle(2'b11, AW'(i), AW'(i), rand60(), rand60(), 1'b0, '0, '0);
        compute_drain();

        // Rotated write then both rotations on read, plus same-cycle read/write of one row
        a = rand60(); b2 = rand60();
        compute_begin();
        compute_cycle(2'b11, 11'h405, 11'h005, a, b2, 1'b0, '0, '0);
        compute_cycle(2'b00, '0, '0, '0, '0, 1'b1, 11'h405, 11'h005);
        compute_cycle(2'b00, '0, '0, '0, '0, 1'b1, 11'h005, 11'h005);
        compute_cycle(2'b11, 11'h405, 11'h005, rand60(), rand60(), 1'b1, 11'h405, 11'h005);
        compute_cycle(2'b00, '0, '0, '0, '0, 1'b1, 11'h405, 11'h005);
        compute_drain();

        // Random compute traffic
        compute_begin();
        for (int i = 0; i < 300; i++)
            compute_cycle(2'($urandom), AW'($urandom), AW'($urandom), rand60(), rand60(),
                          1'($urandom), AW'($urandom), AW'($urandom));
        compute_drain();

        // LOAD across the row wrap, then read the rows back
        do_load(10'h3FE, 3, 1'b0);
        compute_begin();
        read_row(10'h3FE); read_row(10'h3FF); read_row(10'h000);
        compute_drain();

        // STORE with alternating ready
        do_store(10'h3FA, 8, 0, -1);

        // Compute write during LOAD is dropped and flagged
        r = $urandom_range(0, 1023);
        do_load(r, 2, 1'b1);
        chk("conflict_sticky", 128'(wr_conflict), 128'(1));
        compute_begin();
        read_row((r + 512) % 1024);
        compute_drain();
        do_load($urandom_range(0, 1023), 1, 1'b0);

        zero_len();

        // Reset in the middle of a STORE
        do_store($urandom_range(0, 1023), 12, 2, 2);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_store($urandom_range(0, 1023), 4, 2, -1);

        // Random transfers mixed with compute bursts
        for (int k = 0; k < 8; k++) begin
            r = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 1) do_load(r, $urandom_range(1, 12), 1'b0);
            else do_store(r, $urandom_range(1, 12), 1, -1);
            compute_begin();
            for (int i = 0; i < 20; i++)
                compute_cycle(2'($urandom), AW'($urandom), AW'($urandom), rand60(), rand60(),
                              1'($urandom), AW'(r + i), AW'(r + i));
            compute_drain();
        end
        zero_len();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
